// File: rtl/fop_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// fop_sweep_ctrl
//   Sequencer and self-checker for the three implementations of the 4-input fop
//   function (gate-level, dataflow, behavioural). A start request sweeps every
//   input code 0..2^N-1 onto the shared fop input bus, one code per clock.
//   Each cycle the three fop outputs are compared against the golden truth
//   table, and the mismatches are recorded in result registers.
//
// Parameters
//   N      fop input width; the sweep covers 2^N codes
//   TRUTH  golden table, bit k = expected fop output for input code k
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active-high
//   start       in   begin a sweep (sampled only in IDLE)
//   abort       in   abandon a running sweep
//   out_g       in   output of gate-level fop instance
//   out_d       in   output of dataflow fop instance
//   out_b       in   output of behavioural fop instance
//   fop_in      out  registered code driven to all three fop instances
//   busy        out  high while a sweep is running
//   done        out  one-cycle pulse at sweep completion
//   err_cnt     out  number of codes on which any implementation mismatched
//   fail_map    out  bit k set if code k mismatched
//   first_fail  out  lowest failing code, valid when fail_vld=1
//   fail_vld    out  at least one mismatch recorded
//   err_gdb     out  sticky per-implementation mismatch flags {g,d,b}
// ----------------------------------------------------------------------------
module fop_sweep_ctrl #(
  parameter int               N     = 4,
  parameter logic [(1<<N)-1:0] TRUTH = 16'h29AF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                out_g,
  input  logic                out_d,
  input  logic                out_b,
  output logic [N-1:0]        fop_in,
  output logic                busy,
  output logic                done,
  output logic [N:0]          err_cnt,
  output logic [(1<<N)-1:0]   fail_map,
  output logic [N-1:0]        first_fail,
  output logic                fail_vld,
  output logic [2:0]          err_gdb
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [N-1:0] IDX_LAST = {N{1'b1}};

  state_t              state_q,      state_d;
  logic [N-1:0]        fop_in_q,     fop_in_d;
  logic                busy_q,       busy_d;
  logic                done_q,       done_d;
  logic [N:0]          err_cnt_q,    err_cnt_d;
  logic [(1<<N)-1:0]   fail_map_q,   fail_map_d;
  logic [N-1:0]        first_fail_q, first_fail_d;
  logic                fail_vld_q,   fail_vld_d;
  logic [2:0]          err_gdb_q,    err_gdb_d;

  logic                exp_s;
  logic [2:0]          miss_s;

  // The code on fop_in_q is the sweep index; the fop outputs settle within
  // the cycle and are judged against the table entry for that code.
  always_comb begin
    exp_s  = TRUTH[fop_in_q];
    miss_s = {out_g, out_d, out_b} ^ {3{exp_s}};
  end

  // Next-state and result update logic.
  always_comb begin
    state_d      = state_q;
    fop_in_d     = fop_in_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_cnt_d    = err_cnt_q;
    fail_map_d   = fail_map_q;
    first_fail_d = first_fail_q;
    fail_vld_d   = fail_vld_q;
    err_gdb_d    = err_gdb_q;

    case (state_q)
      ST_IDLE: begin
        fop_in_d = {N{1'b0}};
        busy_d   = 1'b0;
        // A start coinciding with abort is refused outright.
        if (start && !abort) begin
          state_d      = ST_RUN;
          busy_d       = 1'b1;
          err_cnt_d    = {(N+1){1'b0}};
          fail_map_d   = {(1<<N){1'b0}};
          first_fail_d = {N{1'b0}};
          fail_vld_d   = 1'b0;
          err_gdb_d    = 3'b000;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (abort) begin
          // Current code is dropped; partial results stay visible.
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          fop_in_d = {N{1'b0}};
        end else begin
          if (|miss_s) begin
            fail_map_d[fop_in_q] = 1'b1;
            err_cnt_d            = err_cnt_q + {{N{1'b0}}, 1'b1};
            err_gdb_d            = err_gdb_q | miss_s;
            if (!fail_vld_q) begin
              first_fail_d = fop_in_q;
              fail_vld_d   = 1'b1;
            end else begin
              first_fail_d = first_fail_q;
            end
          end else begin
            err_cnt_d = err_cnt_q;
          end

          if (fop_in_q == IDX_LAST) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            fop_in_d = {N{1'b0}};
          end else begin
            fop_in_d = fop_in_q + {{(N-1){1'b0}}, 1'b1};
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end

      default: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        fop_in_d = {N{1'b0}};
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fop_in_q     <= {N{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_cnt_q    <= {(N+1){1'b0}};
      fail_map_q   <= {(1<<N){1'b0}};
      first_fail_q <= {N{1'b0}};
      fail_vld_q   <= 1'b0;
      err_gdb_q    <= 3'b000;
    end else begin
      state_q      <= state_d;
      fop_in_q     <= fop_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_cnt_q    <= err_cnt_d;
      fail_map_q   <= fail_map_d;
      first_fail_q <= first_fail_d;
      fail_vld_q   <= fail_vld_d;
      err_gdb_q    <= err_gdb_d;
    end
  end

  assign fop_in     = fop_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_cnt    = err_cnt_q;
  assign fail_map   = fail_map_q;
  assign first_fail = first_fail_q;
  assign fail_vld   = fail_vld_q;
  assign err_gdb    = err_gdb_q;

endmodule

// File: tb/tb_fop_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fop_sweep_ctrl
//   Bench for fop_sweep_ctrl. The three fop instances are modelled as the
//   golden table XOR a per-implementation flip mask, so any fault pattern can
//   be injected. Expected results are derived from the masks directly.
// ----------------------------------------------------------------------------
module tb_fop_sweep_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        out_g;
  logic        out_d;
  logic        out_b;
  logic [3:0]  fop_in;
  logic        busy;
  logic        done;
  logic [4:0]  err_cnt;
  logic [15:0] fail_map;
  logic [3:0]  first_fail;
  logic        fail_vld;
  logic [2:0]  err_gdb;

  logic [15:0] truth_tb;
  logic [15:0] flip_g;
  logic [15:0] flip_d;
  logic [15:0] flip_b;

  int checks;
  int errors;

  fop_sweep_ctrl #(.N(4), .TRUTH(16'h29AF)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .out_g      (out_g),
    .out_d      (out_d),
    .out_b      (out_b),
    .fop_in     (fop_in),
    .busy       (busy),
    .done       (done),
    .err_cnt    (err_cnt),
    .fail_map   (fail_map),
    .first_fail (first_fail),
    .fail_vld   (fail_vld),
    .err_gdb    (err_gdb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural fop instances: golden value, optionally flipped per code.
  assign out_g = truth_tb[fop_in] ^ flip_g[fop_in];
  assign out_d = truth_tb[fop_in] ^ flip_d[fop_in];
  assign out_b = truth_tb[fop_in] ^ flip_b[fop_in];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {err_cnt, fail_map, first_fail, fail_vld, err_gdb} after the
  // first 'limit' codes have been evaluated.
  function automatic logic [28:0] model(input logic [15:0] fg, input logic [15:0] fd,
                                        input logic [15:0] fb, input int limit);
    logic [15:0] keep;
    logic [15:0] u;
    logic [4:0]  cnt;
    logic [3:0]  first;
    keep = 16'h0000;
    for (int i = 0; i < limit; i++) keep[i] = 1'b1;
    fg = fg & keep;
    fd = fd & keep;
    fb = fb & keep;
    u = fg | fd | fb;
    cnt = 5'd0;
    first = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (u[i]) begin
        cnt   = cnt + 5'd1;
        first = i[3:0];
      end
    end
    return {cnt, u, first, |u, {|fg, |fd, |fb}};
  endfunction

  // One complete sweep from IDLE; checks timing of busy/fop_in/done and the
  // final results. With hold=1, start stays high throughout.
  task automatic run_full_sweep(input string name, input bit hold);
    logic [28:0] exp_res;
    exp_res = model(flip_g, flip_d, flip_b, 16);
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({busy, done, fop_in} !== {1'b1, 1'b0, k[3:0]}) begin
        errors++;
        $display("FAIL %s run k=%0d busy/done/fop_in got %b/%b/%0d want 1/0/%0d",
                 name, k, busy, done, fop_in, k);
      end
      step();
    end
    checks++;
    if ({busy, done, fop_in} !== {1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL %s done_cycle busy/done/fop_in got %b/%b/%0d want 0/1/0",
               name, busy, done, fop_in);
    end
    checks++;
    if ({err_cnt, fail_map, first_fail, fail_vld, err_gdb} !== exp_res) begin
      errors++;
      $display("FAIL %s results got cnt=%0d map=%h first=%0d vld=%b gdb=%b want %h",
               name, err_cnt, fail_map, first_fail, fail_vld, err_gdb, exp_res);
    end
    step();
    checks++;
    if ({busy, done, fop_in} !== {1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL %s idle_after busy/done/fop_in got %b/%b/%0d want 0/0/0",
               name, busy, done, fop_in);
    end
    checks++;
    if ({err_cnt, fail_map, first_fail, fail_vld, err_gdb} !== exp_res) begin
      errors++;
      $display("FAIL %s results_held got cnt=%0d map=%h want %h", name, err_cnt, fail_map, exp_res);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({busy, done, fop_in, err_cnt, fail_map, first_fail, fail_vld, err_gdb} !== 35'd0) begin
      errors++;
      $display("FAIL reset_initial got busy=%b done=%b fop_in=%0d cnt=%0d map=%h want all 0",
               busy, done, fop_in, err_cnt, fail_map);
    end
    rst = 1'b0;
    // Reset in the middle of a faulty sweep.
    flip_g = 16'h0000; flip_d = 16'hFFFF; flip_b = 16'h0000;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 7; k++) step();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({busy, done, fop_in, err_cnt, fail_map, first_fail, fail_vld, err_gdb} !== 35'd0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b fop_in=%0d cnt=%0d map=%h gdb=%b want all 0",
               busy, done, fop_in, err_cnt, fail_map, err_gdb);
    end
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({busy, done, fop_in} !== 6'd0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b done=%b fop_in=%0d want 0/0/0", busy, done, fop_in);
    end
  endtask

  task automatic test_clean();
    flip_g = 16'h0000; flip_d = 16'h0000; flip_b = 16'h0000;
    run_full_sweep("clean", 1'b0);
    checks++;
    if ({err_cnt, fail_map, fail_vld, err_gdb} !== {5'd0, 16'h0000, 1'b0, 3'b000}) begin
      errors++;
      $display("FAIL clean_const got cnt=%0d map=%h vld=%b gdb=%b want 0/0000/0/000",
               err_cnt, fail_map, fail_vld, err_gdb);
    end
  endtask

  task automatic test_stuck_b();
    flip_g = 16'h0000; flip_d = 16'h0000; flip_b = ~truth_tb;
    run_full_sweep("stuck_b", 1'b0);
    checks++;
    if ({err_cnt, fail_map, first_fail, fail_vld, err_gdb} !== {5'd7, 16'hD650, 4'd4, 1'b1, 3'b001}) begin
      errors++;
      $display("FAIL stuck_b_const got cnt=%0d map=%h first=%0d vld=%b gdb=%b want 7/d650/4/1/001",
               err_cnt, fail_map, first_fail, fail_vld, err_gdb);
    end
  endtask

  task automatic test_inv_g();
    flip_g = 16'hFFFF; flip_d = 16'h0000; flip_b = 16'h0000;
    run_full_sweep("inv_g", 1'b0);
    checks++;
    if ({err_cnt, fail_map, first_fail, fail_vld, err_gdb} !== {5'd16, 16'hFFFF, 4'd0, 1'b1, 3'b100}) begin
      errors++;
      $display("FAIL inv_g_const got cnt=%0d map=%h first=%0d vld=%b gdb=%b want 16/ffff/0/1/100",
               err_cnt, fail_map, first_fail, fail_vld, err_gdb);
    end
  endtask

  task automatic test_abort();
    logic [28:0] exp_res;
    flip_g = 16'h0012; flip_d = 16'h0400; flip_b = 16'h8008;
    exp_res = model(flip_g, flip_d, flip_b, 5);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (fop_in !== 4'd5) begin
      errors++;
      $display("FAIL abort_pos fop_in got %0d want 5", fop_in);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({busy, done, fop_in} !== 6'd0) begin
      errors++;
      $display("FAIL abort_idle busy/done/fop_in got %b/%b/%0d want 0/0/0", busy, done, fop_in);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL abort_no_done k=%0d busy/done got %b/%b want 0/0", k, busy, done);
      end
    end
    checks++;
    if ({err_cnt, fail_map, first_fail, fail_vld, err_gdb} !== exp_res) begin
      errors++;
      $display("FAIL abort_partial got cnt=%0d map=%h first=%0d gdb=%b want %h",
               err_cnt, fail_map, first_fail, err_gdb, exp_res);
    end
    // start together with abort in IDLE is refused.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if ({busy, fop_in} !== 5'd0) begin
      errors++;
      $display("FAIL start_abort_idle busy/fop_in got %b/%0d want 0/0", busy, fop_in);
    end
    run_full_sweep("after_abort", 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      flip_g = 16'($urandom) & 16'($urandom);
      flip_d = 16'($urandom) & 16'($urandom) & 16'($urandom);
      flip_b = (r == 0) ? 16'h0000 : (16'($urandom) & 16'($urandom));
      run_full_sweep($sformatf("random%0d", r), 1'b0);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) step();
    end
  endtask

  task automatic test_back_to_back();
    flip_g = 16'h0100; flip_d = 16'h0000; flip_b = 16'h0000;
    run_full_sweep("b2b_first", 1'b1);
    flip_g = 16'h0000; flip_d = 16'h2004; flip_b = 16'h0000;
    run_full_sweep("b2b_second", 1'b1);
    start = 1'b0;
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_stop busy/done got %b/%b want 0/0", busy, done);
    end
  endtask

  initial begin
    truth_tb = 16'h29AF;
    flip_g = 16'h0000;
    flip_d = 16'h0000;
    flip_b = 16'h0000;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    checks = 0;
    errors = 0;
    #1;
    test_reset();
    test_clean();
    test_stuck_b();
    test_inv_g();
    test_abort();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
